// File: rtl/dmac_burst_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dmac_burst_arbiter
//  Purpose  : Round-robin burst arbiter for a DMA controller. Up to N_MASTER
//             requesters compete for one shared beat channel. The winner keeps
//             the channel for a whole burst of (len+1) beats, then the FSM
//             spends one IDLE cycle re-arbitrating.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req_i / len_i     - per-master burst request and length-1
//             gnt_o             - registered one-hot grant, held for the burst
//             src_valid_i/src_ready_o/src_data_i - per-master beat channel
//             dst_valid_o/dst_ready_i/dst_data_o/dst_last_o - shared channel
//             busy_o            - high while a burst is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module dmac_burst_arbiter #(
   parameter int N_MASTER  = 4,
   parameter int DATA_SIZE = 32,
   parameter int LEN_W     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTER-1:0]  req_i,
   input  logic [LEN_W-1:0]     len_i       [N_MASTER],
   output logic [N_MASTER-1:0]  gnt_o,
   input  logic [N_MASTER-1:0]  src_valid_i,
   output logic [N_MASTER-1:0]  src_ready_o,
   input  logic [DATA_SIZE-1:0] src_data_i  [N_MASTER],
   output logic                 dst_valid_o,
   input  logic                 dst_ready_i,
   output logic [DATA_SIZE-1:0] dst_data_o,
   output logic                 dst_last_o,
   output logic                 busy_o
);

   localparam int IDX_W = $clog2(N_MASTER);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   state_t              state_q,    state_d;
   logic [LEN_W-1:0]    cnt_q,      cnt_d;
   logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
   logic [IDX_W-1:0]    sel_q,      sel_d;
   logic [N_MASTER-1:0] gnt_q,      gnt_d;

   logic [IDX_W-1:0]    rr_pick;
   logic                rr_found;
   logic                beat_xfer;

   // Index (base + offs) mod N_MASTER; offs is 1..N_MASTER so one
   // subtraction is enough to wrap.
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                               input int               offs);
      int sum;
      sum = int'(base) + offs;
      if (sum >= N_MASTER) begin
         sum = sum - N_MASTER;
      end
      return IDX_W'(sum);
   endfunction

   // Round-robin search starting just after the previous winner, so the
   // previous winner is visited last and therefore has lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = last_gnt_q;
      for (int k = 1; k <= N_MASTER; k++) begin
         if (!rr_found && req_i[rr_idx(last_gnt_q, k)]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx(last_gnt_q, k);
         end
      end
   end

   // Datapath mux. gnt_q is all-zero in IDLE, which forces every
   // src_ready_o low there without a separate state qualifier.
   assign busy_o      = (state_q == ST_BURST);
   assign gnt_o       = gnt_q;
   assign dst_valid_o = busy_o & src_valid_i[sel_q];
   assign dst_data_o  = busy_o ? src_data_i[sel_q] : '0;
   assign dst_last_o  = busy_o & (cnt_q == '0);
   assign src_ready_o = gnt_q & {N_MASTER{dst_ready_i}};
   assign beat_xfer   = dst_valid_o & dst_ready_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_gnt_d = last_gnt_q;
      sel_d      = sel_q;
      gnt_d      = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (rr_found) begin
               state_d = ST_BURST;
               sel_d   = rr_pick;
               // Length is captured once; later len_i changes are ignored.
               cnt_d   = len_i[rr_pick];
               gnt_d   = N_MASTER'(1) << rr_pick;
            end
         end
         ST_BURST: begin
            if (beat_xfer) begin
               if (cnt_q == '0) begin
                  state_d    = ST_IDLE;
                  last_gnt_d = sel_q;
                  gnt_d      = '0;
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // Reset value of last_gnt points at the highest index so master 0 is
   // the first one found by the search.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         last_gnt_q <= IDX_W'(N_MASTER - 1);
         sel_q      <= '0;
         gnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         sel_q      <= sel_d;
         gnt_q      <= gnt_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/dmac_burst_arbiter.md
DMAC_BURST_ARBITER -- requirements
Module: dmac_burst_arbiter

Interface
REQ-001 SHALL take parameters, one per line:
- N_MASTER, 4, number of requesters, 2..8.
- DATA_SIZE, 32, data width.
- LEN_W, 4, burst-length field width; beats = len+1.

REQ-002 SHALL have these ports, one per line, with one clock; reset is synchronous and active-high:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_i[N_MASTER]  input  1 each  burst request, level; held until own burst completes.
- len_i[N_MASTER]  input  LEN_W each  burst length minus one; valid while req_i high.
- gnt_o[N_MASTER]  output  1 each  registered one-hot grant; high for the whole burst.
- src_valid_i[N_MASTER]  input  1 each  beat valid from master.
- src_ready_o[N_MASTER]  output  1 each  beat ready to master.
- src_data_i[N_MASTER]  input  DATA_SIZE each  beat data from master.
- dst_valid_o  output  1  beat valid to shared channel.
- dst_ready_i  input  1  beat ready from shared channel.
- dst_data_o  output  DATA_SIZE  beat data to shared channel.
- dst_last_o  output  1  final beat of current burst.
- busy_o  output  1  high in BURST state.

Function
REQ-003 SHALL implement a two-state FSM, IDLE and BURST.
REQ-004 In IDLE with any req_i high, SHALL grant the first requester found searching round-robin from (last_gnt+1) mod N_MASTER upward with wrap, and go to BURST next cycle.
REQ-005 SHALL assert gnt_o[g] from the cycle after req_i is sampled in IDLE; grant latency is 1 cycle.
REQ-006 On grant, SHALL latch len_i[g] into the beat counter cnt; len_i changes after the grant SHALL be ignored.
REQ-007 In BURST, the datapath outputs SHALL be:
- dst_valid_o = src_valid_i[g]
- dst_data_o = src_data_i[g]
- src_ready_o[g] = dst_ready_i
- all other src_ready_o = 0
These are combinational paths.
REQ-008 In IDLE, dst_valid_o, dst_last_o, busy_o and every src_ready_o and gnt_o SHALL be 0, and dst_data_o SHALL be 0.
REQ-009 A beat SHALL transfer only on a cycle where dst_valid_o and dst_ready_i are both high; each transfer decrements cnt.
REQ-010 dst_last_o SHALL equal (state==BURST && cnt==0).
REQ-011 A transfer with cnt==0 SHALL end the burst as follows:
- return to IDLE;
- set last_gnt = g;
- deassert gnt_o the next cycle.
REQ-012 The grant SHALL NOT change mid-burst regardless of req_i activity; req_i is sampled only in IDLE.
REQ-013 SHALL insert exactly one IDLE cycle between consecutive bursts, so a back-to-back burst sees a 2-cycle gap from last beat to next gnt_o.
REQ-014 A master still requesting after its burst SHALL receive lowest priority at the next arbitration.
REQ-015 With len=0, SHALL perform a single-beat burst with dst_last_o high on its only beat.
REQ-016 Stalls, where src_valid_i is low or dst_ready_i is low, SHALL hold cnt and the grant indefinitely; there is no timeout.
REQ-017 With no req_i high in IDLE, SHALL remain in IDLE and leave last_gnt unchanged.

Reset
REQ-018 While rst is high at a clock edge, SHALL set state=IDLE, cnt=0 and last_gnt=N_MASTER-1, so master 0 has first priority.
REQ-019 Following a reset, all outputs SHALL equal the IDLE values in REQ-008 from the next cycle.
REQ-020 Reset asserted mid-burst SHALL abort the burst without completing remaining beats.

Verification
REQ-021 Bench SHALL cover these scenarios:
- Reset, then req_i[0] with len=3 and dst_ready_i=1, src_valid_i=1 continuously -> gnt_o[0] one cycle after request; 4 beats on consecutive cycles; dst_last_o on beat 4; IDLE after.
- All four req_i high, len=0 each, held -> grant order 0,1,2,3,0; each burst 1 beat; 2-cycle spacing between beats.
- After last_gnt=3, only req_i[1] and req_i[2] high -> master 1 is granted first.
- Master 2 granted with len=2; dst_ready_i low for 3 cycles mid-burst -> cnt held; no beat lost; dst_last_o only on the third accepted beat; src_ready_o of other masters stays 0.
- len_i[0] changed from 3 to 7 after grant -> burst still ends after 4 beats.
- rst asserted after 2 of 8 beats -> next cycle all outputs 0; subsequent req_i[3] alone is granted normally, and with all requesting master 0 wins first.
